// File: rtl/joy_port_reader.sv
// Serial controller port poller: pulses the OUT0 strobe, clocks NBITS bits in on /OE and presents them as one word.
// Optional JOY_DOUBLE_READ_EN runs a second pass and flags any mismatch between the two passes on err.
module joy_port_reader #(
  parameter int NBITS         = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int LOW_CYCLES    = 2,
  parameter int HIGH_CYCLES   = 2
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             start,
  input  logic             sdata_i,
  output logic             strobe_o,
  output logic             n_oe,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] data,
  output logic             err
);

  localparam int MAXSL = (STROBE_CYCLES > LOW_CYCLES) ? STROBE_CYCLES : LOW_CYCLES;
  localparam int MAXC  = (MAXSL > HIGH_CYCLES) ? MAXSL : HIGH_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW    = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] S_LOAD   = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] L_LOAD   = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] H_LOAD   = CW'(HIGH_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    BIT_LOW,
    BIT_HIGH,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] data_q;
  logic             done_q;
`ifdef JOY_DOUBLE_READ_EN
  logic             pass_q, pass_d;
  logic [NBITS-1:0] first_q, first_d;
  logic             err_q;
`endif

  // Each phase counter counts down from its reload value; reaching zero ends the phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef JOY_DOUBLE_READ_EN
    pass_d  = pass_q;
    first_d = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STROBE;
          cnt_d   = S_LOAD;
`ifdef JOY_DOUBLE_READ_EN
          pass_d  = 1'b0;
`endif
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = BIT_LOW;
          cnt_d   = L_LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BIT_LOW: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = ~sdata_i;
          state_d        = BIT_HIGH;
          cnt_d          = H_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BIT_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = BIT_LOW;
          cnt_d   = L_LOAD;
        end else begin
`ifdef JOY_DOUBLE_READ_EN
          if (!pass_q) begin
            first_d = shreg_q;
            pass_d  = 1'b1;
            state_d = STROBE;
            cnt_d   = S_LOAD;
          end else begin
            state_d = FINISH;
          end
`else
          state_d = FINISH;
`endif
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The published word and done pulse are registered together when FINISH retires.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      done_q  <= (state_q == FINISH);
      if (state_q == FINISH) data_q <= shreg_q;
    end
  end

`ifdef JOY_DOUBLE_READ_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pass_q  <= 1'b0;
      first_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pass_q  <= pass_d;
      first_q <= first_d;
      if (state_q == FINISH) err_q <= (first_q != shreg_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign strobe_o = (state_q == STROBE);
  assign n_oe     = (state_q != BIT_LOW);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign data     = data_q;

endmodule
